// File: rtl/dsm_pkg.sv
// Shared definitions for the DSM receive path: CIC register width, the
// bitstream-to-level mapping and a generic saturating narrower.
package dsm_pkg;

    localparam int DSM_BIT_POS = 1;
    localparam int DSM_BIT_NEG = -1;

    function automatic int cic_width(input int order, input int decim_log2);
        return order * decim_log2 + 2;
    endfunction

    // Clamps value to the signed range of 'width' bits; sat reports a clamp.
    function automatic logic signed [31:0] sat_to_width(
        input  logic signed [31:0] value,
        input  int                 width,
        output logic               sat
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] result;
        hi     = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo     = -(32'sd1 <<< (width - 1));
        result = value;
        sat    = 1'b0;
        if (value > hi) begin
            result = hi;
            sat    = 1'b1;
        end else if (value < lo) begin
            result = lo;
            sat    = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dsm_cic_decimator_comb.sv
// Single CIC comb stage: o_data = i_data - previous accepted i_data, with the
// delay register advancing only on the decimated-rate enable.
module cic_comb
    import dsm_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;

    // NOTE: assign the hold value first so every path writes dly_d and no latch is inferred.
    always_comb begin
        dly_d = dly_q;
        if (i_en) begin
            dly_d = i_data;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    // Modulo-2^W difference; intermediate wrap cancels across the chain.
    assign o_data = i_data - dly_q;

endmodule

// File: rtl/dsm_cic_decimator.sv
// sinc^ORDER decimator turning a 1-bit DSM stream into signed PCM samples.
// Optional build macro DSM_DEC_WARMUP_SUPPRESS_EN hides the first ORDER outputs after reset.
module dsm_cic_decimator
    import dsm_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ORDER      = 2,
    parameter int DECIM_LOG2 = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_sample,
    input  logic                         i_bit,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_sat
);

    localparam int W     = cic_width(ORDER, DECIM_LOG2);
    localparam int SHIFT = W - 1 - DATA_WIDTH;

    logic [1:0]            rst_sync_q;
    logic [1:0]            rst_sync_d;
    logic                  rst_sync_n;
    logic [W-1:0]          int_q [ORDER];
    logic [W-1:0]          int_d [ORDER];
    logic [DECIM_LOG2-1:0] cnt_q;
    logic [DECIM_LOG2-1:0] cnt_d;
    logic                  dec_stb_q;
    logic                  dec_stb_d;
    logic [W-1:0]          snap_q;
    logic [W-1:0]          snap_d;
    logic                  blk_done;
    logic [W-1:0]          comb_w [ORDER+1];
    logic                  present;
    logic signed [DATA_WIDTH-1:0] o_data_q;
    logic signed [DATA_WIDTH-1:0] o_data_d;
    logic                  o_valid_q;
    logic                  o_valid_d;
    logic                  o_sat_q;
    logic                  o_sat_d;

    // Reset asserts asynchronously, releases two edges later in the clock domain.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    // Each stage adds the freshly updated stage before it, so the value
    // latched on the block-completing edge already includes the R-th bit.
    always_comb begin
        logic [W-1:0] acc;
        acc = i_bit ? W'(DSM_BIT_POS) : W'(DSM_BIT_NEG);
        for (int k = 0; k < ORDER; k++) begin
            acc      = acc + int_q[k];
            int_d[k] = i_sample ? acc : int_q[k];
        end
    end

    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        // NOTE: the integrator array is reset like any flop; a stale sum would corrupt every later block.
        always_ff @(posedge i_clk or negedge rst_sync_n) begin
            if (!rst_sync_n) begin
                int_q[k] <= '0;
            end else begin
                int_q[k] <= int_d[k];
            end
        end
    end

    always_comb begin
        blk_done  = i_sample && (cnt_q == '1);
        cnt_d     = i_sample ? cnt_q + 1'b1 : cnt_q;
        dec_stb_d = blk_done;
        snap_d    = blk_done ? int_d[ORDER-1] : snap_q;
    end

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cnt_q     <= '0;
            dec_stb_q <= 1'b0;
            snap_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dec_stb_q <= dec_stb_d;
            snap_q    <= snap_d;
        end
    end

    assign comb_w[0] = snap_q;

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        cic_comb #(
            .W (W)
        ) u_comb (
            .i_clk   (i_clk),
            .i_rst_n (rst_sync_n),
            .i_en    (dec_stb_q),
            .i_data  (comb_w[k]),
            .o_data  (comb_w[k+1])
        );
    end

`ifdef DSM_DEC_WARMUP_SUPPRESS_EN
    localparam int WARM_W = $clog2(ORDER + 1);

    logic [WARM_W-1:0] warm_q;
    logic [WARM_W-1:0] warm_d;

    // Counts decimated outputs up to ORDER; outputs surface only once it is full.
    always_comb begin
        warm_d  = warm_q;
        present = 1'b0;
        if (dec_stb_q) begin
            if (warm_q == WARM_W'(ORDER)) begin
                present = 1'b1;
            end else begin
                warm_d = warm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            warm_q <= '0;
        end else begin
            warm_q <= warm_d;
        end
    end
`else
    always_comb begin
        present = dec_stb_q;
    end
`endif

    always_comb begin
        logic signed [W-1:0]  y_w;
        logic signed [31:0]   y_sat;
        logic                 sat_flag;
        y_w       = $signed(comb_w[ORDER]) >>> SHIFT;
        y_sat     = sat_to_width(32'(y_w), DATA_WIDTH, sat_flag);
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;
        o_sat_d   = o_sat_q;
        if (present) begin
            o_valid_d = 1'b1;
            o_data_d  = DATA_WIDTH'(y_sat);
            o_sat_d   = sat_flag;
        end
    end

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_sat_q   <= 1'b0;
        end else begin
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_sat_q   <= o_sat_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator: an unbounded-integer sinc model fills a
// scoreboard as bits are driven; a negedge monitor pops it on every o_valid.
module tb_dsm_cic_decimator;

    localparam int DW    = 4;
    localparam int ORD   = 2;
    localparam int DL2   = 4;
    localparam int R     = 1 << DL2;
    localparam int SHIFT = ORD * DL2 + 1 - DW;
    localparam longint YMAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint YMIN = -(64'sd1 <<< (DW - 1));

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 sat;
        int                   cyc;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 sample;
    logic                 din;
    logic signed [DW-1:0] o_data;
    logic                 o_valid;
    logic                 o_sat;

    int     total;
    int     bad;
    int     cyc;
    int     last_valid;
    int     exp_spacing;
    exp_t   sb[$];
    longint s_sum [ORD];
    longint hist [ORD+1];
    int     m_cnt;
    int     m_warm;

    dsm_cic_decimator #(
        .DATA_WIDTH (DW),
        .ORDER      (ORD),
        .DECIM_LOG2 (DL2)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sample (sample),
        .i_bit    (din),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_sat    (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Reference: cascaded running sums, ORD-th difference across block boundaries.
    task automatic model_step(input logic b);
        longint v;
        longint coef;
        longint y;
        exp_t   e;
        s_sum[0] += b ? 64'sd1 : -64'sd1;
        for (int k = 1; k < ORD; k++) s_sum[k] += s_sum[k-1];
        m_cnt++;
        if (m_cnt == R) begin
            m_cnt = 0;
            for (int j = ORD; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = s_sum[ORD-1];
            v    = 0;
            coef = 1;
            for (int j = 0; j <= ORD; j++) begin
                v    += ((j % 2) == 0) ? coef * hist[j] : -coef * hist[j];
                coef  = coef * (ORD - j) / (j + 1);
            end
            y     = v >>> SHIFT;
            e.sat = 1'b0;
            if (y > YMAX) begin y = YMAX; e.sat = 1'b1; end
            if (y < YMIN) begin y = YMIN; e.sat = 1'b1; end
            e.data = DW'(y);
            e.cyc  = cyc + 2;
`ifdef DSM_DEC_WARMUP_SUPPRESS_EN
            if (m_warm < ORD) m_warm++;
            else sb.push_back(e);
`else
            sb.push_back(e);
`endif
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ORD; k++) s_sum[k] = 0;
        for (int j = 0; j <= ORD; j++) hist[j] = 0;
        m_cnt  = 0;
        m_warm = 0;
        sb.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input int gap);
        sample = 1'b1;
        din    = b;
        model_step(b);
        tick();
        sample = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_idle(input string tag);
        total++;
        assert (o_data === '0) else begin
            bad++; $error("FAIL %s_data: observed=%0d expected=0", tag, o_data);
        end
        total++;
        assert (o_valid === 1'b0) else begin
            bad++; $error("FAIL %s_valid: observed=%b expected=0", tag, o_valid);
        end
        total++;
        assert (o_sat === 1'b0) else begin
            bad++; $error("FAIL %s_sat: observed=%b expected=0", tag, o_sat);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n  = 1'b0;
        sample = 1'b0;
        din    = 1'b0;
        model_reset();
        #1;
        check_idle(tag);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) last_valid = -1;
        if (o_valid === 1'b1) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++; $error("FAIL unexpected_valid: observed=valid at cycle %0d expected=none", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                assert (o_data === e.data) else begin
                    bad++; $error("FAIL data: observed=%0d expected=%0d", o_data, e.data);
                end
                total++;
                assert (o_sat === e.sat) else begin
                    bad++; $error("FAIL sat: observed=%b expected=%b", o_sat, e.sat);
                end
                total++;
                assert (cyc === e.cyc) else begin
                    bad++; $error("FAIL latency: observed=cycle %0d expected=cycle %0d", cyc, e.cyc);
                end
            end
            if (exp_spacing != 0 && last_valid >= 0) begin
                total++;
                assert ((cyc - last_valid) === exp_spacing) else begin
                    bad++; $error("FAIL spacing: observed=%0d expected=%0d", cyc - last_valid, exp_spacing);
                end
            end
            last_valid = cyc;
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        last_valid  = -1;
        exp_spacing = 0;
        rst_n       = 1'b0;
        sample      = 1'b0;
        din         = 1'b0;
        model_reset();
        repeat (3) tick();
        check_idle("por");
        rst_n = 1'b1;
        repeat (4) tick();

        // Constant ones: 4, then saturated 7s.
        exp_spacing = R;
        for (int i = 0; i < 4 * R; i++) send(1'b1, 0);
        drain();

        // Constant zeros: -5, then -8s.
        do_reset("rst_t2");
        for (int i = 0; i < 3 * R; i++) send(1'b0, 0);
        drain();

        // Alternating 1,0: zero throughout.
        do_reset("rst_t3");
        for (int i = 0; i < 3 * R; i++) send(((i % 2) == 0) ? 1'b1 : 1'b0, 0);
        drain();

        // 1,1,1,0 repeated: settles at +4.
        do_reset("rst_t4");
        for (int i = 0; i < 4 * R; i++) send(((i % 4) == 3) ? 1'b0 : 1'b1, 0);
        drain();

        // Sparse strobes: one bit every third clock.
        do_reset("rst_t5");
        exp_spacing = 3 * R;
        for (int i = 0; i < 3 * R; i++) send(1'b1, 2);
        drain();

        // Reset after 9 bits of the third block.
        do_reset("rst_t6a");
        exp_spacing = R;
        for (int i = 0; i < 2 * R + 9; i++) send(1'b1, 0);
        rst_n  = 1'b0;
        sample = 1'b0;
        model_reset();
        #1;
        check_idle("midblock_rst");
        repeat (3) tick();
        check_idle("midblock_hold");
        rst_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 3 * R; i++) send(1'b1, 0);
        drain();

        // Random bits with random strobe gaps.
        do_reset("rst_t7");
        exp_spacing = 0;
        for (int i = 0; i < 4 * R; i++) send(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        drain();

        total++;
        assert (sb.size() === 0) else begin
            bad++; $error("FAIL drain: observed=%0d pending expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
